// File: rtl/wino_pkg.sv
// Shared WinoCNN types: tile geometry, partial-sum word width, buffer FSM states
// and the tile <-> word packing that matches the CIM adder's bit order.
package wino_pkg;

    localparam int unsigned TILE_N    = 6;
    localparam int unsigned ELEM_W    = 12;
    localparam int unsigned DATA_W    = 512;
    localparam int unsigned TILE_BITS = TILE_N * TILE_N * ELEM_W;

    typedef logic signed [0:TILE_N-1][0:TILE_N-1][ELEM_W-1:0] tile_t;

    typedef enum logic [2:0] {
        CLEAR,
        ACCUM,
        FLUSH,
        DRAIN,
        CLEAR_DONE
    } state_t;

    // Element (i,j) lives at bits [(i*TILE_N+j)*ELEM_W +: ELEM_W]; unused upper bits are zero.
    function automatic logic [DATA_W-1:0] pack_tile(input tile_t t);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < TILE_N; i++) begin
            for (int unsigned j = 0; j < TILE_N; j++) begin
                w[(i * TILE_N + j) * ELEM_W +: ELEM_W] = t[i][j];
            end
        end
        return w;
    endfunction

    function automatic tile_t unpack_tile(input logic [DATA_W-1:0] w);
        tile_t t;
        for (int unsigned i = 0; i < TILE_N; i++) begin
            for (int unsigned j = 0; j < TILE_N; j++) begin
                t[i][j] = w[(i * TILE_N + j) * ELEM_W +: ELEM_W];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/psum_ram.sv
// 1R1W synchronous partial-sum RAM, one-cycle read latency, read-old on a same-address
// collision; the caller resolves read-after-write hazards.
module psum_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its word until the next read, which keeps drain output stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/psum_buffer.sv
// Partial-sum buffer around the CIM adder: aligns PE tiles with stored sums, writes
// sums back with RAW forwarding, and drains/zeroes the buffer on request.
module psum_buffer
    import wino_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  tile_t             pe_tile_i,
    input  logic [ADDR_W-1:0] pe_addr_i,
    input  logic              pe_valid_i,
    output logic              pe_ready_o,
    output tile_t             cim_tile_o,
    output logic [ADDR_W-1:0] cim_addr_o,
    output logic              cim_valid_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] cim_result_i,
    input  logic              cim_result_valid_i,
    input  logic [ADDR_W-1:0] cim_result_addr_i,
    input  logic              drain_start_i,
    output logic [DATA_W-1:0] drain_data_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic              drain_done_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] acc_wdata;

    logic              pe_fire, acc_wr, drain_xfer, drain_issue, last_xfer, done_d;
    logic              ram_re, ram_we;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign pe_fire     = pe_ready_o && pe_valid_i;
    assign acc_wr      = cim_valid_o && cim_result_valid_i;
    assign acc_wdata   = pack_tile(unpack_tile(cim_result_i));
    assign drain_xfer  = drain_valid_o && drain_ready_i;
    assign drain_issue = (state == DRAIN) && !rd_done && (!drain_valid_o || drain_ready_i);
    assign last_xfer   = drain_xfer && (drain_addr_o == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus RAM port steering; write sources are exclusive by state.
    always_comb begin
        next_state = state;
        ram_re     = 1'b0;
        ram_raddr  = pe_addr_i;
        ram_we     = 1'b0;
        ram_waddr  = cim_result_addr_i;
        ram_wdata  = acc_wdata;
        done_d     = 1'b0;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == LAST_ADDR) next_state = ACCUM;
            end
            ACCUM: begin
                ram_re = pe_fire;
                ram_we = acc_wr;
                if (drain_start_i) next_state = FLUSH;
            end
            FLUSH: begin
                ram_we     = acc_wr;
                next_state = DRAIN;
            end
            DRAIN: begin
                ram_re    = drain_issue;
                ram_raddr = rd_addr;
                ram_we    = drain_xfer;
                ram_waddr = drain_addr_o;
                ram_wdata = '0;
                if (last_xfer) begin
                    next_state = CLEAR_DONE;
                    done_d     = 1'b1;
                end
            end
            CLEAR_DONE: next_state = ACCUM;
            default:    next_state = CLEAR;
        endcase
        if (!rst_n) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_addr      <= '0;
            rd_addr       <= '0;
            rd_done       <= 1'b0;
            cim_valid_o   <= 1'b0;
            cim_tile_o    <= '0;
            cim_addr_o    <= '0;
            byp_hit       <= 1'b0;
            byp_data      <= '0;
            drain_valid_o <= 1'b0;
            drain_addr_o  <= '0;
            drain_done_o  <= 1'b0;
            pe_ready_o    <= 1'b0;
            busy_o        <= 1'b1;
        end else begin
            if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
            cim_valid_o <= pe_fire;
            // A stage-0 read colliding with this edge's write takes the new sum.
            byp_hit <= pe_fire && acc_wr && (cim_result_addr_i == pe_addr_i);
            if (pe_fire) begin
                cim_tile_o <= pe_tile_i;
                cim_addr_o <= pe_addr_i;
                byp_data   <= acc_wdata;
            end
            if (state != DRAIN) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (drain_issue) begin
                rd_addr      <= rd_addr + ADDR_W'(1);
                rd_done      <= (rd_addr == LAST_ADDR);
                drain_addr_o <= rd_addr;
            end
            if (drain_issue) begin
                drain_valid_o <= 1'b1;
            end else if (drain_xfer) begin
                drain_valid_o <= 1'b0;
            end
            drain_done_o <= done_d;
            pe_ready_o   <= (next_state == ACCUM);
            busy_o       <= !((next_state == ACCUM) && !pe_fire);
        end
    end

    assign mem_data_o   = byp_hit ? byp_data : ram_rdata;
    assign drain_data_o = ram_rdata;

    psum_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata)
    );

endmodule
